// File: rtl/microseq_p.sv
`default_nettype none
// ============================================================================
// Module      : microseq_p
// Description : Microprogram sequencer with a writable control store, a
//               condition mux, a micro-stack and an optional loop counter
//               (compiled in by defining MICROSEQ_LOOP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module microseq_p #(
    parameter int CW    = 48,
    parameter int AW    = 8,
    parameter int NCOND = 4,
    parameter int SD    = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 STALL,
    input  logic                 MOC,
    input  logic [NCOND-1:0]     COND,
    input  logic [AW-1:0]        MAP_ADDR,
    input  logic [7:0]           LOOP_INIT,
    input  logic                 UCS_WE,
    input  logic [AW-1:0]        UCS_ADDR,
    input  logic [CW+AW+7:0]     UCS_WDATA,
    output logic [CW-1:0]        CTL,
    output logic [AW-1:0]        UPC,
    output logic                 ERR
);

    localparam int W   = CW + AW + 8;
    localparam int SPW = $clog2(SD + 1);

    localparam logic [2:0] c_op_jump  = 3'd0;
    localparam logic [2:0] c_op_inc   = 3'd1;
    localparam logic [2:0] c_op_map   = 3'd2;
    localparam logic [2:0] c_op_cbr   = 3'd3;
    localparam logic [2:0] c_op_cwait = 3'd4;
    localparam logic [2:0] c_op_call  = 3'd5;
    localparam logic [2:0] c_op_ret   = 3'd6;
    localparam logic [2:0] c_op_loop  = 3'd7;

    logic [W-1:0]   r_store [2**AW];
    logic [W-1:0]   r_cw;
    logic [AW-1:0]  r_upc;
    logic           r_err;
    logic [AW-1:0]  r_stack [2**SPW];
    logic [SPW-1:0] r_sp;

    logic [2:0]     w_n;
    logic           w_inv;
    logic [3:0]     w_s;
    logic [AW-1:0]  w_cr;
    logic [15:0]    w_src;
    logic           w_c;
    logic [AW-1:0]  w_inc;
    logic [AW-1:0]  w_next;
    logic [SPW-1:0] w_sp_dec;
    logic [AW-1:0]  w_top;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_err_set;
    logic           w_map;
    logic           w_loop_dec;

`ifdef MICROSEQ_LOOP_EN
    logic [7:0]     r_loop;
`else
    logic           w_unused_loop_init;
    assign w_unused_loop_init = ^LOOP_INIT;
`endif

    assign w_n      = r_cw[W-1 -: 3];
    assign w_inv    = r_cw[W-4];
    assign w_s      = r_cw[W-5 -: 4];
    assign w_cr     = r_cw[CW +: AW];
    assign w_inc    = r_upc + AW'(1);
    assign w_sp_dec = r_sp - SPW'(1);
    assign w_top    = r_stack[w_sp_dec];
    assign w_full   = (r_sp == SPW'(SD));
    assign w_empty  = (r_sp == '0);

    // Unused selector codes above NCOND read as constant 1.
    always_comb begin
        w_src    = '1;
        w_src[0] = MOC;
        for (int i = 1; i <= NCOND; i++) begin
            w_src[i] = COND[i-1];
        end
    end

    assign w_c = w_src[w_s] ^ w_inv;

    always_comb begin
        w_next     = w_inc;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_err_set  = 1'b0;
        w_map      = 1'b0;
        w_loop_dec = 1'b0;
        case (w_n)
            c_op_jump:  w_next = w_cr;
            c_op_inc:   w_next = w_inc;
            c_op_map: begin
                w_next = MAP_ADDR;
                w_map  = 1'b1;
            end
            c_op_cbr:   w_next = w_c ? w_cr : w_inc;
            c_op_cwait: w_next = w_c ? w_inc : r_upc;
            c_op_call: begin
                w_next = w_cr;
                if (w_full) begin
                    w_err_set = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            c_op_ret: begin
                if (w_empty) begin
                    w_next    = '0;
                    w_err_set = 1'b1;
                end else begin
                    w_next = w_top;
                    w_pop  = 1'b1;
                end
            end
            c_op_loop: begin
`ifdef MICROSEQ_LOOP_EN
                if (r_loop != 8'd0) begin
                    w_next     = w_cr;
                    w_loop_dec = 1'b1;
                end else begin
                    w_next = w_inc;
                end
`else
                w_next = w_inc;
`endif
            end
            default: w_next = w_inc;
        endcase
    end

    // Store writes ignore STALL and RST; reads see pre-write contents.
    always_ff @(posedge CLK) begin
        if (UCS_WE) begin
            r_store[UCS_ADDR] <= UCS_WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && !STALL && w_push) begin
            r_stack[r_sp] <= w_inc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_upc <= '0;
            r_cw  <= '0;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (!STALL) begin
            r_upc <= w_next;
            r_cw  <= r_store[w_next];
            if (w_push) begin
                r_sp <= r_sp + SPW'(1);
            end else if (w_pop) begin
                r_sp <= w_sp_dec;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef MICROSEQ_LOOP_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_loop <= 8'd0;
        end else if (!STALL) begin
            if (w_map) begin
                r_loop <= LOOP_INIT;
            end else if (w_loop_dec) begin
                r_loop <= r_loop - 8'd1;
            end
        end
    end
`else
    logic w_unused_loop_ctl;
    assign w_unused_loop_ctl = w_map ^ w_loop_dec;
`endif

    assign CTL = r_cw[CW-1:0];
    assign UPC = r_upc;
    assign ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_microseq_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_microseq_p
// Description : Scoreboard bench for microseq_p; directed microprograms.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microseq_p;

    localparam int CW    = 48;
    localparam int AW    = 8;
    localparam int NCOND = 4;
    localparam int SD    = 4;
    localparam int W     = CW + AW + 8;

    localparam logic [2:0] JUMP = 3'd0, INC = 3'd1, MAP = 3'd2, CBR = 3'd3;
    localparam logic [2:0] CWAIT = 3'd4, CALL = 3'd5, RET = 3'd6, LOOP = 3'd7;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             moc;
    logic [NCOND-1:0] cond;
    logic [AW-1:0]    map_addr;
    logic [7:0]       loop_init;
    logic             ucs_we;
    logic [AW-1:0]    ucs_addr;
    logic [W-1:0]     ucs_wdata;
    logic [CW-1:0]    ctl;
    logic [AW-1:0]    upc;
    logic             err;

    microseq_p #(.CW(CW), .AW(AW), .NCOND(NCOND), .SD(SD)) dut (
        .CLK       (clk),
        .RST       (rst),
        .STALL     (stall),
        .MOC       (moc),
        .COND      (cond),
        .MAP_ADDR  (map_addr),
        .LOOP_INIT (loop_init),
        .UCS_WE    (ucs_we),
        .UCS_ADDR  (ucs_addr),
        .UCS_WDATA (ucs_wdata),
        .CTL       (ctl),
        .UPC       (upc),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   tag;
        logic [AW-1:0] upc;
        logic [CW-1:0] ctl;
        logic          err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] tag_n    = 16'd0;

    function automatic logic [W-1:0] mw(input logic [2:0] n, input logic inv,
                                        input logic [3:0] s, input logic [AW-1:0] cr,
                                        input logic [CW-1:0] c);
        return {n, inv, s, cr, c};
    endfunction

    task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
        ucs_we    = 1'b1;
        ucs_addr  = a;
        ucs_wdata = d;
        @(posedge clk);
        #1;
        ucs_we = 1'b0;
    endtask

    // One clock edge; the state expected after that edge goes to the scoreboard.
    task automatic step(input logic [AW-1:0] u, input logic [CW-1:0] c, input logic e);
        exp_t x;
        @(posedge clk);
        #1;
        x.tag = tag_n;
        x.upc = u;
        x.ctl = c;
        x.err = e;
        exp_q.push_back(x);
        tag_n++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (upc !== x.upc || ctl !== x.ctl || err !== x.err) begin
                failures++;
                $display("FAIL step%0d: got upc=%h ctl=%h err=%b, required upc=%h ctl=%h err=%b",
                         x.tag, upc, ctl, err, x.upc, x.ctl, x.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; moc = 1'b0; cond = '0; map_addr = '0;
        loop_init = 8'd0; ucs_we = 1'b0; ucs_addr = '0; ucs_wdata = '0;

        // Basic INC/JUMP loop
        load(8'h00, mw(INC,  1'b0, 4'd0, 8'h00, 48'hA));
        load(8'h01, mw(JUMP, 1'b0, 4'd0, 8'h00, 48'hB));
        step(8'h00, 48'h0, 1'b0);
        rst = 1'b0;
        step(8'h00, 48'hA, 1'b0);
        step(8'h01, 48'hB, 1'b0);
        step(8'h00, 48'hA, 1'b0);
        step(8'h01, 48'hB, 1'b0);

        // CWAIT on MOC, then a reset in the middle of a wait
        rst = 1'b1;
        load(8'h00, mw(JUMP,  1'b0, 4'd0, 8'h05, 48'h1));
        load(8'h05, mw(CWAIT, 1'b0, 4'd0, 8'h00, 48'h55));
        load(8'h06, mw(JUMP,  1'b0, 4'd0, 8'h06, 48'h66));
        step(8'h00, 48'h0, 1'b0);
        rst = 1'b0; moc = 1'b0;
        step(8'h00, 48'h1, 1'b0);
        step(8'h05, 48'h55, 1'b0);
        step(8'h05, 48'h55, 1'b0);
        step(8'h05, 48'h55, 1'b0);
        step(8'h05, 48'h55, 1'b0);
        moc = 1'b1;
        step(8'h06, 48'h66, 1'b0);
        moc = 1'b0; rst = 1'b1;
        step(8'h00, 48'h0, 1'b0);
        rst = 1'b0;
        step(8'h00, 48'h1, 1'b0);
        step(8'h05, 48'h55, 1'b0);
        rst = 1'b1;
        step(8'h00, 48'h0, 1'b0);
        rst = 1'b0; moc = 1'b1;
        step(8'h00, 48'h1, 1'b0);
        step(8'h05, 48'h55, 1'b0);
        step(8'h06, 48'h66, 1'b0);

        // CBR with inverted COND[1]; S beyond NCOND is constant 1
        rst = 1'b1; moc = 1'b0;
        load(8'h00, mw(JUMP, 1'b0, 4'd0,  8'h10, 48'h2));
        load(8'h10, mw(CBR,  1'b1, 4'd2,  8'h20, 48'h10));
        load(8'h11, mw(JUMP, 1'b0, 4'd0,  8'h10, 48'h11));
        load(8'h20, mw(CBR,  1'b1, 4'd15, 8'h40, 48'h20));
        load(8'h21, mw(JUMP, 1'b0, 4'd0,  8'h10, 48'h21));
        step(8'h00, 48'h0, 1'b0);
        rst = 1'b0; cond = 4'b0010;
        step(8'h00, 48'h2, 1'b0);
        step(8'h10, 48'h10, 1'b0);
        step(8'h11, 48'h11, 1'b0);
        cond = 4'b0000;
        step(8'h10, 48'h10, 1'b0);
        step(8'h20, 48'h20, 1'b0);
        step(8'h21, 48'h21, 1'b0);
        step(8'h10, 48'h10, 1'b0);

        // Five nested CALLs into a depth-4 stack, then five RETs
        rst = 1'b1;
        load(8'h00, mw(JUMP, 1'b0, 4'd0, 8'h80, 48'h1));
        load(8'h80, mw(CALL, 1'b0, 4'd0, 8'h90, 48'h80));
        load(8'h90, mw(CALL, 1'b0, 4'd0, 8'hA0, 48'h90));
        load(8'hA0, mw(CALL, 1'b0, 4'd0, 8'hB0, 48'hA0));
        load(8'hB0, mw(CALL, 1'b0, 4'd0, 8'hC0, 48'hB0));
        load(8'hC0, mw(CALL, 1'b0, 4'd0, 8'hD0, 48'hC0));
        load(8'hD0, mw(RET,  1'b0, 4'd0, 8'h00, 48'hD0));
        load(8'hB1, mw(RET,  1'b0, 4'd0, 8'h00, 48'hB1));
        load(8'hA1, mw(RET,  1'b0, 4'd0, 8'h00, 48'hA1));
        load(8'h91, mw(RET,  1'b0, 4'd0, 8'h00, 48'h91));
        load(8'h81, mw(RET,  1'b0, 4'd0, 8'h00, 48'h81));
        step(8'h00, 48'h0, 1'b0);
        rst = 1'b0;
        step(8'h00, 48'h1, 1'b0);
        step(8'h80, 48'h80, 1'b0);
        step(8'h90, 48'h90, 1'b0);
        step(8'hA0, 48'hA0, 1'b0);
        step(8'hB0, 48'hB0, 1'b0);
        step(8'hC0, 48'hC0, 1'b0);
        step(8'hD0, 48'hD0, 1'b1);
        step(8'hB1, 48'hB1, 1'b1);
        step(8'hA1, 48'hA1, 1'b1);
        step(8'h91, 48'h91, 1'b1);
        step(8'h81, 48'h81, 1'b1);
        step(8'h00, 48'h1, 1'b1);
        step(8'h80, 48'h80, 1'b1);

        // Reset wins over STALL; MAP then LOOP
        rst = 1'b1; stall = 1'b1;
        load(8'h00, mw(MAP,  1'b0, 4'd0, 8'h00, 48'h3));
        load(8'h60, mw(LOOP, 1'b0, 4'd0, 8'h60, 48'h60));
        load(8'h61, mw(JUMP, 1'b0, 4'd0, 8'h61, 48'h61));
        step(8'h00, 48'h0, 1'b0);
        rst = 1'b0; stall = 1'b0; map_addr = 8'h60; loop_init = 8'd3;
        step(8'h00, 48'h3, 1'b0);
        step(8'h60, 48'h60, 1'b0);
`ifdef MICROSEQ_LOOP_EN
        step(8'h60, 48'h60, 1'b0);
        step(8'h60, 48'h60, 1'b0);
        step(8'h60, 48'h60, 1'b0);
`endif
        step(8'h61, 48'h61, 1'b0);
        step(8'h61, 48'h61, 1'b0);

        // STALL while rewriting the current word; same-edge write reads old data
        rst = 1'b1;
        load(8'h00, mw(INC,  1'b0, 4'd0, 8'h00, 48'h70));
        load(8'h01, mw(INC,  1'b0, 4'd0, 8'h00, 48'h71));
        load(8'h02, mw(JUMP, 1'b0, 4'd0, 8'h00, 48'h72));
        step(8'h00, 48'h0, 1'b0);
        rst = 1'b0;
        step(8'h00, 48'h70, 1'b0);
        step(8'h01, 48'h71, 1'b0);
        stall = 1'b1; ucs_we = 1'b1; ucs_addr = 8'h01;
        ucs_wdata = mw(INC, 1'b0, 4'd0, 8'h00, 48'h99);
        step(8'h01, 48'h71, 1'b0);
        step(8'h01, 48'h71, 1'b0);
        stall = 1'b0; ucs_we = 1'b0;
        step(8'h02, 48'h72, 1'b0);
        ucs_we = 1'b1; ucs_addr = 8'h00;
        ucs_wdata = mw(INC, 1'b0, 4'd0, 8'h00, 48'hAB);
        step(8'h00, 48'h70, 1'b0);
        ucs_we = 1'b0;
        step(8'h01, 48'h99, 1'b0);
        step(8'h02, 48'h72, 1'b0);
        step(8'h00, 48'hAB, 1'b0);
        step(8'h01, 48'h99, 1'b0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left in scoreboard, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
